adder_seq: RTL and testbench
============================

# adder_seq

Multi-cycle 32-bit add/subtract unit for the ALU that reuses one 8-bit byte adder sequentially. A controller latches both operands on `start`, steps the byte adder through four byte positions least-significant first, and chains the carry between them through a register. It then presents the registered result with carry and overflow flags. It is the area-reduced alternative to a full-width combinational adder in the ALU datapath.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of 8; byte count `NB = WIDTH/8`
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; accepted only in IDLE or DONE
- `op`  in  1  0 = add, 1 = subtract (see Configuration)
- `a`  in  WIDTH  operand A, sampled on accepted `start`
- `b`  in  WIDTH  operand B, sampled on accepted `start`
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse when the result is valid
- `result`  out  WIDTH  sum or difference; holds until the next accepted `start`
- `cout`  out  1  carry out of the MSB; for subtract, 1 means no borrow
- `ovf`  out  1  signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE + `start`:
  - latch `a` into `a_q`
  - latch `b_eff = op ? ~b : b` into `b_q`
  - `carry_q <= op`, `idx <= 0`
  - clear `result`, `cout` and `ovf`
  - go to RUN
- RUN, each cycle, byte `idx`:
  - `{c, s} = a_q[idx] + b_q[idx] + carry_q`, 9 bits
  - `result[idx*8 +: 8] <= s`, `carry_q <= c`
  - when `idx == NB-1`: `cout <= c`, `ovf <= (a_q[MSB] == b_q[MSB]) && (s[7] != a_q[MSB])`, go to DONE
  - otherwise `idx <= idx+1`
- DONE:
  - `done = 1` for exactly this cycle
  - `start` here is accepted as in IDLE (back-to-back) and goes to RUN
  - otherwise go to IDLE
- `start` during RUN is ignored. No queueing; the in-flight operation is unaffected.
- All arithmetic is modulo 2^WIDTH. Carry out of byte NB-1 appears only on `cout`.
- Reset at any time, including mid-RUN:
  - next state IDLE
  - `busy = 0`, `done = 0`
  - `result = 0`, `cout = 0`, `ovf = 0`
  - `idx = 0`, `carry_q = 0`
  - the partial operation is discarded

## Timing
- Accepted `start` at edge T.
- RUN occupies the cycles after edges T..T+NB-1.
- DONE is visible after edge T+NB: `done = 1` and `result`/`cout`/`ovf` are valid. Latency is NB+1 cycles, 5 for the default.
- Throughput: one operation per NB+1 cycles with back-to-back `start` held in DONE.
- `busy` is registered via state decode: high exactly NB cycles per operation.
- `result` bytes update progressively during RUN. Consumers must sample only when `done = 1` or afterwards.
- Operands are captured at acceptance. Changes on `a`, `b` or `op` after that have no effect.

## Configuration
- `ADDER_SEQ_SUB_EN`:
  - Defined: `op` selects subtract, implemented as B inverted with carry-in 1.
  - Undefined: the `op` port still exists but is ignored; `b_eff = b` and carry-in is 0, so the unit always adds.

## Structure
- Shared package `adder_seq_pkg`:
  - state enum `{IDLE, RUN, DONE}`
  - `OP_ADD = 1'b0`, `OP_SUB = 1'b1`
  - byte width constant `BYTE_W = 8`
- One sub-module, `byte_adder_ci`: 8-bit combinational adder with carry-in. Ports `(s[7:0], cout, a[7:0], b[7:0], cin)`. It is the only arithmetic in the block; the top level holds only the FSM, index counter, operand/carry registers and the result register.

## Test plan
- `a=0x0000000C`, `b=0x00000003`, `op=0` → `done` 5 cycles after `start`; `result=0x0000000F`, `cout=0`, `ovf=0`; `busy` high exactly 4 cycles.
- `a=0xFFFFFFFF`, `b=0xC0000000`, `op=0` → `result=0xBFFFFFFF`, `cout=1`, `ovf=0`.
- Carry chain: `a=0x00FFFFFF`, `b=0x00000001` → `result=0x01000000`, `cout=0`. Then `a=0x7FFFFFFF`, `b=0x00000001` → `result=0x80000000`, `ovf=1`.
- With `ADDER_SEQ_SUB_EN`:
  - `a=5`, `b=7`, `op=1` → `result=0xFFFFFFFE`, `cout=0`
  - `a=7`, `b=5`, `op=1` → `result=0x00000002`, `cout=1`
- Without the macro: `a=7`, `b=5`, `op=1` → `result=0x0000000C`.
- `start` with new operands pulsed mid-RUN → ignored; the original result is delivered. `start` held in DONE → next operation begins with no IDLE cycle.
- `reset` asserted during the 2nd RUN cycle → next cycle state IDLE, all outputs 0. A following `start` with `a=1`, `b=1` → `result=0x00000002`.

Source files
------------

// File: rtl/adder_seq_pkg.sv
//------------------------------------------------------------------------------
// adder_seq_pkg : shared types and constants for the sequential byte adder
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int BYTE_W = 8;

endpackage

`default_nettype wire

// File: rtl/byte_adder_ci.sv
//------------------------------------------------------------------------------
// byte_adder_ci : 8-bit combinational adder with carry-in and carry-out
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module byte_adder_ci (
  output logic [7:0] s,
  output logic       cout,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

`default_nettype wire

// File: rtl/adder_seq.sv
//------------------------------------------------------------------------------
// adder_seq : multi-cycle add/subtract reusing one byte adder, LSB byte first.
//             Subtract support enabled by defining ADDER_SEQ_SUB_EN.
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NB    = WIDTH / BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  state_t             r_state;
  state_t             w_state_nx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_eff;
  logic               w_cin;
  logic [BYTE_W-1:0]  w_a_byte;
  logic [BYTE_W-1:0]  w_b_byte;
  logic [BYTE_W-1:0]  w_s;
  logic               w_c;

`ifdef ADDER_SEQ_SUB_EN
  // Two's-complement subtract: invert B and inject carry-in of one.
  assign w_b_eff = (i_op == OP_SUB) ? ~i_b : i_b;
  assign w_cin   = (i_op == OP_SUB);
`else
  logic w_unused_op;
  assign w_unused_op = i_op;
  assign w_b_eff     = i_b;
  assign w_cin       = 1'b0;
`endif

  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_idx == IDX_W'(NB - 1));
  assign w_a_byte = r_a[r_idx*BYTE_W +: BYTE_W];
  assign w_b_byte = r_b[r_idx*BYTE_W +: BYTE_W];

  byte_adder_ci u_byte_adder (
    .s    (w_s),
    .cout (w_c),
    .a    (w_a_byte),
    .b    (w_b_byte),
    .cin  (r_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nx = RUN;
      RUN:     if (w_last)  w_state_nx = DONE;
      DONE:    w_state_nx = i_start ? RUN : IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= i_a;
      r_b      <= w_b_eff;
      r_carry  <= w_cin;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == RUN) begin
      r_result[r_idx*BYTE_W +: BYTE_W] <= w_s;
      r_carry                          <= w_c;
      if (w_last) begin
        r_cout <= w_c;
        // Signed overflow: like-signed operands yield an opposite-signed sum.
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[BYTE_W-1] != r_a[WIDTH-1]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign o_busy   = (r_state == RUN);
  assign o_done   = (r_state == DONE);
  assign o_result = r_result;
  assign o_cout   = r_cout;
  assign o_ovf    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_adder_seq.sv
//------------------------------------------------------------------------------
// tb_adder_seq : directed vector table plus multi-cycle corner sequences
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_adder_seq;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic        i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;
  logic        o_cout;
  logic        o_ovf;

  int n_pass  = 0;
  int n_total = 0;

  adder_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_cout   (o_cout),
    .o_ovf    (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Issues one operation and checks latency, busy length and results.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] er, input logic ec, input logic eo);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    i_a = a; i_b = b; i_op = op; i_start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) i_start = 1'b0;
      if (o_busy) busy_cnt++;
      if (o_done) begin lat = n; break; end
    end
    chk({name, "_latency"}, lat, 5);
    chk({name, "_busy"}, busy_cnt, 4);
    chk({name, "_result"}, o_result, er);
    chk({name, "_cout"}, {31'b0, o_cout}, {31'b0, ec});
    chk({name, "_ovf"}, {31'b0, o_ovf}, {31'b0, eo});
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h0000000C, 32'h00000003, 1'b0, 32'h0000000F, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'hC0000000, 1'b0, 32'hBFFFFFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
`ifdef ADDER_SEQ_SUB_EN
    vecs[6] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[7] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[8] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
`else
    vecs[6] = '{32'h00000005, 32'h00000007, 1'b1, 32'h0000000C, 1'b0, 1'b0};
    vecs[7] = '{32'h00000007, 32'h00000005, 1'b1, 32'h0000000C, 1'b0, 1'b0};
    vecs[8] = '{32'h80000000, 32'h00000001, 1'b1, 32'h80000001, 1'b0, 1'b0};
`endif

    reset = 1'b1; i_start = 1'b0; i_op = 1'b0; i_a = '0; i_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_done", {31'b0, o_done}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_flags", {30'b0, o_cout, o_ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
             vecs[i].res, vecs[i].cout, vecs[i].ovf);

    // Result holds in IDLE after the done pulse.
    @(posedge clk); #1;
    chk("hold_done", {31'b0, o_done}, 32'd0);
    chk("hold_result", o_result, vecs[8].res);

    // Start pulsed mid-RUN with new operands must be ignored.
    begin
      int lat;
      lat = 0;
      @(negedge clk);
      i_a = 32'h00000001; i_b = 32'h00000002; i_op = 1'b0; i_start = 1'b1;
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk); #1;
        if (n == 1) i_start = 1'b0;
        if (n == 2) begin i_a = 32'h00000100; i_b = 32'h00000100; i_start = 1'b1; end
        if (n == 3) i_start = 1'b0;
        if (o_done) begin lat = n; break; end
      end
      chk("midrun_latency", lat, 5);
      chk("midrun_result", o_result, 32'h00000003);
    end

    // Back-to-back: start held in DONE begins the next op with no IDLE cycle.
    begin
      int lat;
      lat = 0;
      @(negedge clk);
      i_a = 32'h0000000A; i_b = 32'h00000014; i_start = 1'b1;
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk); #1;
        if (n == 1) i_start = 1'b0;
        if (o_done) begin lat = n; break; end
      end
      chk("b2b_first_latency", lat, 5);
      chk("b2b_first_result", o_result, 32'h0000001E);
      i_a = 32'h00000100; i_b = 32'h00000200; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      chk("b2b_busy_next", {31'b0, o_busy}, 32'd1);
      chk("b2b_result_cleared", o_result, 32'd0);
      lat = 0;
      for (int n = 2; n <= 20; n++) begin
        @(posedge clk); #1;
        if (o_done) begin lat = n; break; end
      end
      chk("b2b_second_latency", lat, 5);
      chk("b2b_second_result", o_result, 32'h00000300);
    end

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    i_a = 32'h80000011; i_b = 32'h80000022; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_partial", o_result, 32'h00000033);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", {31'b0, o_busy}, 32'd0);
    chk("midrst_done", {31'b0, o_done}, 32'd0);
    chk("midrst_result", o_result, 32'd0);
    chk("midrst_flags", {30'b0, o_cout, o_ovf}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_stays_idle", {30'b0, o_busy, o_done}, 32'd0);
    run_op("post_rst", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
